// File: rtl/esc_pt_pkg.sv
// Shared types and helpers for the ESC passthrough sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package esc_pt_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_BREAK    = 3'd2,
    ST_GUARD    = 3'd3,
    ST_PASSTHRU = 3'd4,
    ST_EXIT     = 3'd5
  } pt_state_e;

  // Width of a counter able to hold the largest of the three cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/esc_passthrough_ctrl_if.sv
// Register-block / pin-mux facing signal bundle of the passthrough sequencer.
// Latency: n/a (wiring only).
// Backpressure: n/a; pt_req is a level request, no handshake.
interface esc_pt_if
  import esc_pt_pkg::*;
#(
  parameter int NUM_MOTORS = 4
);
  localparam int SEL_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;

  logic               pt_req;
  logic [SEL_W-1:0]   motor_sel;
  logic               timeout_clr;
  logic               dshot_idle;
  logic               bridge_active;
  logic               dshot_enable;
  logic               bridge_enable;
  logic [SEL_W-1:0]   mux_sel;
  logic               force_low_oe;
  logic [STATE_W-1:0] state;
  logic               busy;
  logic               timeout_flag;

  // Register block / surrounding engines side.
  modport master (
    output pt_req, motor_sel, timeout_clr, dshot_idle, bridge_active,
    input  dshot_enable, bridge_enable, mux_sel, force_low_oe, state, busy, timeout_flag
  );

  // Sequencer side.
  modport slave (
    input  pt_req, motor_sel, timeout_clr, dshot_idle, bridge_active,
    output dshot_enable, bridge_enable, mux_sel, force_low_oe, state, busy, timeout_flag
  );

endinterface

// File: rtl/esc_passthrough_ctrl_pt_timer.sv
// Saturating up-counter with synchronous clear and a done-compare against a limit.
// Latency: clear/increment take effect on the next edge; done is combinational on count.
// Backpressure: none; inc simply stalls at the all-ones value.
module pt_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         done
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count;

  // Count up while enabled, clear has priority, never wrap past all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count >= limit);

endmodule

// File: rtl/esc_passthrough_ctrl.sv
// Sequences one ESC pin from DSHOT through break, guard and UART passthrough and back.
// Latency: every output follows the causing input by one clock (registered from next state).
// Backpressure: DRAIN waits on dshot_idle; pt_req is ignored while EXIT settles.
module esc_passthrough_ctrl
  import esc_pt_pkg::*;
#(
  parameter int NUM_MOTORS          = 4,
  parameter int BREAK_CYCLES        = 1_440_000,
  parameter int GUARD_CYCLES        = 72_000,
  parameter int IDLE_TIMEOUT_CYCLES = 0
) (
  input logic  clk,
  input logic  rst_n,
  esc_pt_if.slave bus
);

  localparam int SEL_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam int CNT_W = cnt_width(BREAK_CYCLES, GUARD_CYCLES, IDLE_TIMEOUT_CYCLES);

  // Done fires during the last cycle in a state, so a state with limit N-1 lasts N cycles.
  localparam logic [CNT_W-1:0] BREAK_LIM = CNT_W'((BREAK_CYCLES > 0) ? BREAK_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] IDLE_LIM  =
    CNT_W'((IDLE_TIMEOUT_CYCLES > 0) ? IDLE_TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (IDLE_TIMEOUT_CYCLES != 0);

  pt_state_e        state_q;
  pt_state_e        state_d;
  logic             state_change;
  logic             timeout_hit;
  logic             idle_expired;
  logic             start_seq;
  logic             st_done;
  logic             idle_done;
  logic             idle_clr;
  logic [CNT_W-1:0] st_limit;

  logic             dshot_enable_q;
  logic             bridge_enable_q;
  logic             force_low_oe_q;
  logic             busy_q;
  logic             timeout_flag_q;
  logic [SEL_W-1:0] mux_sel_q;

  // Per-state dwell timer, restarted on every state change.
  assign st_limit = (state_q == ST_BREAK) ? BREAK_LIM : GUARD_LIM;

  pt_timer #(.W(CNT_W)) u_state_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_change),
    .inc   (1'b1),
    .limit (st_limit),
    .done  (st_done)
  );

  // Inactivity timer: only runs in PASSTHRU, any bridge traffic restarts it.
  assign idle_clr = state_change || bus.bridge_active || (state_q != ST_PASSTHRU);

  pt_timer #(.W(CNT_W)) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (idle_clr),
    .inc   (1'b1),
    .limit (IDLE_LIM),
    .done  (idle_done)
  );

  assign idle_expired = TIMEOUT_EN && !bus.bridge_active && idle_done;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a dropped request always beats the inactivity timeout.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.pt_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.pt_req)         state_d = ST_IDLE;
        else if (bus.dshot_idle) state_d = ST_BREAK;
      end
      ST_BREAK: begin
        if (!bus.pt_req)  state_d = ST_EXIT;
        else if (st_done) state_d = ST_GUARD;
      end
      ST_GUARD: begin
        if (!bus.pt_req)  state_d = ST_EXIT;
        else if (st_done) state_d = ST_PASSTHRU;
      end
      ST_PASSTHRU: begin
        if (!bus.pt_req) begin
          state_d = ST_EXIT;
        end else if (idle_expired) begin
          state_d     = ST_EXIT;
          timeout_hit = 1'b1;
        end
      end
      ST_EXIT: begin
        if (st_done) state_d = ST_IDLE;
      end
      default: state_d = ST_EXIT;
    endcase
  end

  assign state_change = (state_d != state_q);
  assign start_seq    = (state_q == ST_IDLE) && (state_d == ST_DRAIN);

  // Output registers decoded from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dshot_enable_q  <= 1'b1;
      bridge_enable_q <= 1'b0;
      force_low_oe_q  <= 1'b0;
      busy_q          <= 1'b0;
      mux_sel_q       <= '0;
      timeout_flag_q  <= 1'b0;
    end else begin
      dshot_enable_q  <= (state_d == ST_IDLE);
      bridge_enable_q <= (state_d == ST_PASSTHRU);
      force_low_oe_q  <= (state_d == ST_BREAK);
      busy_q          <= (state_d != ST_IDLE);
      if (start_seq) mux_sel_q <= bus.motor_sel;
      if (timeout_hit)                         timeout_flag_q <= 1'b1;
      else if (bus.timeout_clr || start_seq)   timeout_flag_q <= 1'b0;
    end
  end

  assign bus.dshot_enable  = dshot_enable_q;
  assign bus.bridge_enable = bridge_enable_q;
  assign bus.force_low_oe  = force_low_oe_q;
  assign bus.busy          = busy_q;
  assign bus.mux_sel       = mux_sel_q;
  assign bus.timeout_flag  = timeout_flag_q;
  assign bus.state         = state_q;

endmodule
